// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the block RAM port arbiter.
// FSM state encodings and default bus widths.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU, debug and RAM signals around the arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_port_arbiter_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_port_arbiter_pkg::DEF_DATA_W
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              gnt_dbg;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output gnt_dbg, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  gnt_dbg, busy
    );

endinterface

// File: rtl/mem_port_arbiter_arb_wait_counter.sv
// Saturating count of CPU grants made while debug is waiting.
// sat tells the arbiter that debug must win the next contest.
module arb_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count;

    assign sat = (count == CW'(MAX_WAIT));

    // Clear wins over increment; hold at MAX_WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between the CPU and the debug/loader port.
// IDLE picks a winner, ISSUE drives the RAM, WAIT covers latency, DONE acks.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic               lat_we;

    logic               cpu_ack_q;
    logic               dbg_ack_q;
    logic [DATA_W-1:0]  cpu_rdata_q;
    logic [DATA_W-1:0]  dbg_rdata_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic               gnt_dbg_q;
    logic               busy_q;

    logic               wait_sat;
    logic               any_req;
    logic               sel_dbg;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               cnt_inc;
    logic               cnt_clr;

    // Winner selection and starvation counter control in IDLE.
    always_comb begin
        any_req   = bus.cpu_req || bus.dbg_req;
        sel_dbg   = bus.dbg_req && (!bus.cpu_req || wait_sat);
        sel_we    = sel_dbg ? bus.dbg_we    : bus.cpu_we;
        sel_addr  = sel_dbg ? bus.dbg_addr  : bus.cpu_addr;
        sel_wdata = sel_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        cnt_inc   = (state == ST_IDLE) && bus.dbg_req && !sel_dbg;
        cnt_clr   = (state == ST_IDLE) && (!bus.dbg_req || sel_dbg);
    end

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .sat (wait_sat)
    );

    // Access sequencer; every output is a register loaded here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            lat_cnt     <= '0;
            lat_we      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            gnt_dbg_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state       <= ST_ISSUE;
                        busy_q      <= 1'b1;
                        gnt_dbg_q   <= sel_dbg;
                        lat_we      <= sel_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                    end
                end
                ST_ISSUE: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= '0;
                    if (MEM_LAT > 1) begin
                        state   <= ST_WAIT;
                        lat_cnt <= LAT_W'(MEM_LAT - 2);
                    end else begin
                        state   <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    if (gnt_dbg_q) begin
                        dbg_ack_q <= 1'b1;
                        if (!lat_we) begin
                            dbg_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        cpu_ack_q <= 1'b1;
                        if (!lat_we) begin
                            cpu_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.gnt_dbg   = gnt_dbg_q;
    assign bus.busy      = busy_q;

endmodule
